// File: rtl/player_ctrl.sv
// Player input conditioning: button synchronizers and debouncers, tick-paced column
// movement with clamping, and the fire FSM that picks a free missile slot and toggles its launch bit.
module player_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 315000,
   parameter int unsigned MOVE_TICKS      = 500000,
   parameter int unsigned STEP            = 2,
   parameter int unsigned COL_MIN         = 0,
   parameter int unsigned COL_MAX         = 624,
   parameter int unsigned COL_INIT        = 312,
   parameter int unsigned COOLDOWN_CYCLES = 4000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_left,
   input  logic        btn_right,
   input  logic        btn_fire,
   input  logic [7:0]  missle_en_xor,
   output logic [11:0] btn_col,
   output logic [7:0]  btn_missle_en,
   output logic        shot_fired
);

   // state | meaning
   // IDLE  | waiting for a fire rise with a free slot
   // ACK   | shot just issued, lasts one cycle
   // COOL  | cooldown counting down, fire rises discarded
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACK  = 2'd1,
      ST_COOL = 2'd2
   } state_t;

   localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int MV_W = (MOVE_TICKS > 1) ? $clog2(MOVE_TICKS) : 1;
   localparam int CD_W = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;

   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [MV_W-1:0] MV_LAST = MV_W'(MOVE_TICKS - 1);
   localparam logic [CD_W-1:0] CD_LAST = CD_W'(COOLDOWN_CYCLES - 1);

   localparam logic [12:0] STEP_X = 13'(STEP);
   localparam logic [12:0] MIN_X  = 13'(COL_MIN);
   localparam logic [12:0] MAX_X  = 13'(COL_MAX);
   localparam logic [11:0] INIT_C = 12'(COL_INIT);

   localparam int B_LEFT  = 0;
   localparam int B_RIGHT = 1;
   localparam int B_FIRE  = 2;

   logic [2:0]      sync1_q, sync2_q;
   logic [2:0]      db_lvl_q, db_lvl_d;
   logic [DB_W-1:0] db_cnt_q [3];
   logic [DB_W-1:0] db_cnt_d [3];
   logic            fire_dly_q;
   logic            fire_rise;

   logic [MV_W-1:0] mv_cnt_q, mv_cnt_d;
   logic            tick;
   logic [11:0]     col_q, col_d;
   logic [12:0]     col_ext, col_dec, col_inc;

   state_t          state_q, state_d;
   logic [CD_W-1:0] cd_cnt_q, cd_cnt_d;
   logic [7:0]      en_q, en_d;
   logic            shot_q, shot_d;
   logic            slot_found;
   logic [1:0]      slot_idx;
   logic            unused_xor_hi;

   assign unused_xor_hi = ^missle_en_xor[7:3];

   // Counter measures how long the synchronized value has disagreed with the accepted level.
   always_comb begin
      db_lvl_d = db_lvl_q;
      for (int i = 0; i < 3; i++) begin
         db_cnt_d[i] = '0;
         if (sync2_q[i] != db_lvl_q[i]) begin
            if (db_cnt_q[i] == DB_LAST) begin
               db_lvl_d[i] = sync2_q[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         db_lvl_q   <= '0;
         fire_dly_q <= 1'b0;
         for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
      end else begin
         sync1_q    <= {btn_fire, btn_right, btn_left};
         sync2_q    <= sync1_q;
         db_lvl_q   <= db_lvl_d;
         fire_dly_q <= db_lvl_q[B_FIRE];
         for (int i = 0; i < 3; i++) db_cnt_q[i] <= db_cnt_d[i];
      end
   end

   assign tick      = (mv_cnt_q == MV_LAST);
   assign mv_cnt_d  = tick ? '0 : mv_cnt_q + 1'b1;
   assign fire_rise = db_lvl_q[B_FIRE] & ~fire_dly_q;

   // 13-bit arithmetic keeps both directions clear of wraparound before clamping.
   always_comb begin
      col_ext = {1'b0, col_q};
      col_dec = col_ext - STEP_X;
      col_inc = col_ext + STEP_X;
      col_d   = col_q;
      if (tick) begin
         if (db_lvl_q[B_LEFT] && !db_lvl_q[B_RIGHT]) begin
            col_d = (col_ext < MIN_X + STEP_X) ? MIN_X[11:0] : col_dec[11:0];
         end else if (db_lvl_q[B_RIGHT] && !db_lvl_q[B_LEFT]) begin
            col_d = (col_inc > MAX_X) ? MAX_X[11:0] : col_inc[11:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mv_cnt_q <= '0;
         col_q    <= INIT_C;
      end else begin
         mv_cnt_q <= mv_cnt_d;
         col_q    <= col_d;
      end
   end

   always_comb begin
      slot_found = 1'b0;
      slot_idx   = 2'd0;
      for (int i = 2; i >= 0; i--) begin
         if (!missle_en_xor[i]) begin
            slot_found = 1'b1;
            slot_idx   = 2'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         cd_cnt_q <= '0;
         en_q     <= '0;
         shot_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cd_cnt_q <= cd_cnt_d;
         en_q     <= en_d;
         shot_q   <= shot_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (fire_rise && slot_found) state_d = ST_ACK;
         ST_ACK:  state_d = ST_COOL;
         ST_COOL: if (cd_cnt_q == '0) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      en_d     = en_q;
      shot_d   = 1'b0;
      cd_cnt_d = cd_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (fire_rise && slot_found) begin
               en_d[slot_idx] = ~en_q[slot_idx];
               shot_d         = 1'b1;
            end
         end
         ST_ACK:  cd_cnt_d = CD_LAST;
         ST_COOL: if (cd_cnt_q != '0) cd_cnt_d = cd_cnt_q - 1'b1;
         default: cd_cnt_d = '0;
      endcase
   end

   assign btn_col       = col_q;
   assign btn_missle_en = en_q;
   assign shot_fired    = shot_q;

endmodule

// File: tb/tb_player_ctrl.sv
// Scoreboard bench for player_ctrl: stimulus pushes expected column steps and launch vectors,
// a negedge monitor pops and compares whenever the column moves or a shot pulse appears.
module tb_player_ctrl;

   localparam int COL_INIT = 312;

   logic        clk = 1'b0;
   logic        rst;
   logic        btn_left, btn_right, btn_fire;
   logic [7:0]  xor_v;
   logic [11:0] col;
   logic [7:0]  en;
   logic        shot;

   logic        left2;
   logic        zero_b;
   logic [7:0]  zero_x;
   logic [11:0] col2;
   logic [7:0]  en2;
   logic        shot2;

   int vecs  = 0;
   int fails = 0;
   int shots_seen = 0;

   int         col_q [$];
   logic [7:0] en_exp_q [$];
   logic [7:0] model_en;

   always #5 clk = ~clk;

   player_ctrl #(
      .DEBOUNCE_CYCLES(4), .MOVE_TICKS(8), .STEP(2), .COL_MIN(0),
      .COL_MAX(624), .COL_INIT(COL_INIT), .COOLDOWN_CYCLES(16)
   ) dut (
      .clk(clk), .rst(rst), .btn_left(btn_left), .btn_right(btn_right),
      .btn_fire(btn_fire), .missle_en_xor(xor_v), .btn_col(col),
      .btn_missle_en(en), .shot_fired(shot)
   );

   // Second instance starting on an odd column to exercise the low clamp from 1.
   player_ctrl #(
      .DEBOUNCE_CYCLES(4), .MOVE_TICKS(8), .STEP(2), .COL_MIN(0),
      .COL_MAX(624), .COL_INIT(1), .COOLDOWN_CYCLES(16)
   ) dut2 (
      .clk(clk), .rst(rst), .btn_left(left2), .btn_right(zero_b),
      .btn_fire(zero_b), .missle_en_xor(zero_x), .btn_col(col2),
      .btn_missle_en(en2), .shot_fired(shot2)
   );

   task automatic check(input string name, input int got, input int exp);
      vecs++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s: got %0d, required %0d", name, got, exp);
      end
   endtask

   // Reference: lowest of slots 0..2 not in flight gets its launch bit toggled.
   task automatic expect_fire(input logic [7:0] x);
      for (int i = 0; i < 3; i++) begin
         if (!x[i]) begin
            model_en[i] = ~model_en[i];
            en_exp_q.push_back(model_en);
            return;
         end
      end
   endtask

   task automatic wait_col_drained(input int budget);
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (col_q.size() == 0) return;
      end
      fails++;
      $display("FAIL col_timeout: %0d column steps still pending, required 0", col_q.size());
      col_q.delete();
   endtask

   task automatic wait_shot(input int budget);
      int s0;
      s0 = shots_seen;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (shots_seen > s0) return;
      end
      fails++;
      $display("FAIL shot_timeout: got no shot_fired within %0d cycles, required one", budget);
   endtask

   task automatic press(input logic [7:0] x, input int hold, input int gap);
      xor_v = x;
      expect_fire(x);
      btn_fire = 1'b1;
      repeat (hold) @(negedge clk);
      btn_fire = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   // Monitor
   initial begin : monitor
      int         prev_col;
      logic [7:0] prev_en;
      logic       prev_shot;
      int         e;
      logic [7:0] ee;
      prev_col  = COL_INIT;
      prev_en   = '0;
      prev_shot = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            prev_col  = COL_INIT;
            prev_en   = '0;
            prev_shot = 1'b0;
         end else begin
            if (int'(col) != prev_col) begin
               if (col_q.size() == 0) begin
                  fails++;
                  $display("FAIL col_unexpected: got %0d, required hold at %0d", col, prev_col);
               end else begin
                  e = col_q.pop_front();
                  check("col_step", int'(col), e);
               end
               prev_col = int'(col);
            end
            if (shot) begin
               shots_seen++;
               if (prev_shot) begin
                  fails++;
                  $display("FAIL shot_width: got shot_fired high 2 cycles, required 1");
               end
               if (en_exp_q.size() == 0) begin
                  fails++;
                  $display("FAIL shot_unexpected: got en=%02h, required no shot", en);
               end else begin
                  ee = en_exp_q.pop_front();
                  check("missle_en", int'(en), int'(ee));
               end
            end else if (en != prev_en) begin
               fails++;
               $display("FAIL en_no_shot: got en=%02h, required %02h", en, prev_en);
            end
            prev_en   = en;
            prev_shot = shot;
         end
      end
   end

   initial begin : watchdog
      #500us;
      $display("FAIL watchdog: got no completion, required finish");
      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails + 1);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      rst = 1'b0; btn_left = 0; btn_right = 0; btn_fire = 0; xor_v = '0;
      left2 = 0; zero_b = 0; zero_x = '0; model_en = '0;
      repeat (3) @(negedge clk);
      check("reset_col", int'(col), COL_INIT);
      check("reset_en", int'(en), 0);
      check("reset_shot", int'(shot), 0);
      check("reset_col2", int'(col2), 1);
      rst = 1'b1;
      left2 = 1'b1;

      // Left hold: four steps, then release.
      for (int v = 310; v >= 304; v -= 2) col_q.push_back(v);
      btn_left = 1'b1;
      wait_col_drained(200);
      btn_left = 1'b0;
      repeat (20) @(negedge clk);
      check("col_after_left", int'(col), 304);
      check("col2_clamp_min", int'(col2), 0);
      check("dut2_idle", int'({en2, shot2}), 0);

      // Both buttons held: no movement expected.
      btn_left = 1'b1; btn_right = 1'b1;
      repeat (60) @(negedge clk);
      btn_left = 1'b0; btn_right = 1'b0;
      repeat (20) @(negedge clk);
      check("col_both_hold", int'(col), 304);

      // Right to the upper clamp, then keep holding.
      for (int v = 306; v <= 624; v += 2) col_q.push_back(v);
      btn_right = 1'b1;
      wait_col_drained(2000);
      repeat (40) @(negedge clk);
      check("col_clamp_max", int'(col), 624);
      btn_right = 1'b0;
      repeat (20) @(negedge clk);

      // Left to the lower clamp, then keep holding.
      for (int v = 622; v >= 0; v -= 2) col_q.push_back(v);
      btn_left = 1'b1;
      wait_col_drained(3000);
      repeat (40) @(negedge clk);
      check("col_clamp_min", int'(col), 0);
      btn_left = 1'b0;
      repeat (20) @(negedge clk);

      // Bouncing fire must never be accepted.
      for (int k = 0; k < 15; k++) begin
         btn_fire = ~btn_fire;
         repeat (2) @(negedge clk);
      end
      btn_fire = 1'b0;
      repeat (20) @(negedge clk);
      check("bounce_en", int'(en), 0);

      // Slot selection, press inside cooldown ignored, press after cooldown.
      xor_v = 8'h01;
      expect_fire(xor_v);
      btn_fire = 1'b1;
      wait_shot(50);
      btn_fire = 1'b0;
      repeat (8) @(negedge clk);
      btn_fire = 1'b1;
      repeat (12) @(negedge clk);
      btn_fire = 1'b0;
      repeat (30) @(negedge clk);
      press(8'h03, 12, 30);
      check("en_after_cooldown", int'(en), 8'h06);

      // Randomized presses with random slot occupancy.
      for (int r = 0; r < 10; r++) begin
         press(8'($urandom), 10 + int'($urandom_range(0, 8)), 30 + int'($urandom_range(0, 10)));
      end

      // No free slot.
      press(8'h07, 12, 30);
      check("en_no_slot", int'(en), int'(model_en));

      // Reset during COOL with fire still held; after release the held button re-arms immediately.
      xor_v = 8'h00;
      expect_fire(xor_v);
      btn_fire = 1'b1;
      wait_shot(50);
      repeat (5) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_mid_en", int'(en), 0);
      check("rst_mid_shot", int'(shot), 0);
      check("rst_mid_col", int'(col), COL_INIT);
      model_en = '0;
      expect_fire(xor_v);
      @(negedge clk);
      rst = 1'b1;
      wait_shot(12);
      btn_fire = 1'b0;
      repeat (30) @(negedge clk);
      check("en_after_reset", int'(en), 8'h01);
      check("pending_shots", en_exp_q.size(), 0);
      check("pending_cols", col_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
      $finish;
   end

endmodule
